regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: a_req  input  1  ALU write-back request; held until a_ack.
REQ-004 SHALL have port: a_addr  input  3  ALU destination register 0-7.
REQ-005 SHALL have port: a_data  input  16  ALU result.
REQ-006 SHALL have port: a_ack  output  1  one-cycle pulse; ALU write performed this cycle.
REQ-007 SHALL have ports m_req, m_addr, m_data, m_ack: same directions, widths and meanings as the a_* ports, for the load (memory) unit.
REQ-008 SHALL have port: hold  input  1  register-file freeze; no grant while high.
REQ-009 SHALL have port: wr_en  output  8  one-hot register write strobe, bit n writes register n.
REQ-010 SHALL have port: wr_data  output  16  write data, valid when wr_en is non-zero.
REQ-011 SHALL have parameter: WIDTH, default 16, data width of a_data, m_data and wr_data.

Function
REQ-012 SHALL implement states IDLE, GNT_A and GNT_M in a 2-bit state register.
REQ-013 SHALL evaluate eligibility each cycle: a_req is ineligible in GNT_A, m_req is ineligible in GNT_M, and both are ineligible when hold=1.
REQ-014 SHALL grant the only eligible requester when exactly one is eligible.
REQ-015 SHALL grant round-robin when both are eligible, choosing the requester not granted last, tracked by a 1-bit last pointer.
REQ-016 SHALL grant M regardless of the pointer when both are eligible and a_addr==m_addr, so the ALU value lands last; the pointer then updates to M.
REQ-017 SHALL register every grant: a decision in cycle N makes the outputs valid in cycle N+1, a fixed one-cycle latency.
REQ-018 SHALL, in the grant cycle, drive wr_en = 1<<addr of the winner, wr_data = winner data, and winner ack = 1 for exactly one cycle.
REQ-019 SHALL move to GNT_A or GNT_M on a grant and to IDLE when no grant is made; transitions are possible from every state.
REQ-020 SHALL allow at most one write per cycle: wr_en is never multi-hot, and a_ack and m_ack are never high together.
REQ-021 SHALL limit each requester to at most one grant every 2 cycles, and SHALL sustain one write per cycle when both requesters hold requests.
REQ-022 SHALL drive wr_en=0, both acks=0 and leave wr_data at its last value in any cycle without a grant.
REQ-023 SHALL, when hold rises, let an already-registered grant complete in that cycle and then issue no further grants until hold falls.
REQ-024 SHALL make no grant while a requester drops req before ack; no abort handshake exists.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, last=A, wr_en=8'h00, wr_data=0, a_ack=0 and m_ack=0.
REQ-026 SHALL make no grant in the first rising edge after reset release, and SHALL sample requests from the second edge on.
REQ-027 SHALL, if reset asserts mid-grant, drop the pending write; a requester holding req is granted again after release.

Verification
REQ-028 SHALL cover: a_req=1, a_addr=3, a_data=16'h1234 held -> next cycle wr_en=8'h08, wr_data=16'h1234, a_ack=1; following cycle a_ack=0.
REQ-029 SHALL cover: a_req and m_req held continuously, addresses 1 and 6, after reset -> grants M, A, M, A on consecutive cycles; wr_en alternates 8'h40, 8'h02.
REQ-030 SHALL cover: both requests with addr 5, a_data=16'h00AA, m_data=16'h00BB -> wr_data=16'h00BB then 16'h00AA; register 5 ends at 16'h00AA.
REQ-031 SHALL cover: hold=1 for 4 cycles with both requests pending -> wr_en=0 and no acks for 4 cycles; first grant in the cycle after hold falls.
REQ-032 SHALL cover: rst_n pulsed low for 1 cycle mid-stream -> all outputs 0 immediately, no ack on the first edge after release, and pending requests granted afterward.
REQ-033 SHALL cover: randomized requests checked against a model -> wr_en one-hot or zero, acks mutually exclusive, no requester idle more than 2 cycles while requesting and hold=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU vs load unit, one write per cycle.
// Registered grants, round-robin with same-address ordering toward the ALU.
module regfile_wb_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic [2:0]       a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ack,
  input  logic             m_req,
  input  logic [2:0]       m_addr,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ack,
  input  logic             hold,
  output logic [7:0]       wr_en,
  output logic [WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_M = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   armed;

  logic             a_elig;
  logic             m_elig;
  logic             pick_a;
  logic             pick_m;
  logic [2:0]       win_addr;
  logic [WIDTH-1:0] win_data;

  always_comb begin
    a_elig = armed & a_req & ~hold & (state != GNT_A);
    m_elig = armed & m_req & ~hold & (state != GNT_M);
    // same destination: M first so the ALU result is the one that sticks
    pick_m = m_elig &
             (~a_elig | (a_addr == m_addr) | ~last);
    pick_a = a_elig & ~pick_m;
    win_addr = pick_m ? m_addr : a_addr;
    win_data = pick_m ? m_data : a_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b0;
      armed   <= 1'b0;
      wr_en   <= 8'h00;
      wr_data <= '0;
      a_ack   <= 1'b0;
      m_ack   <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (1'b1)
        pick_m: begin
          state   <= GNT_M;
          last    <= 1'b1;
          wr_en   <= 8'b1 << win_addr;
          wr_data <= win_data;
          a_ack   <= 1'b0;
          m_ack   <= 1'b1;
        end
        pick_a: begin
          state   <= GNT_A;
          last    <= 1'b0;
          wr_en   <= 8'b1 << win_addr;
          wr_data <= win_data;
          a_ack   <= 1'b1;
          m_ack   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          wr_en <= 8'h00;
          a_ack <= 1'b0;
          m_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        a_ack;
  logic        m_req;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic        m_ack;
  logic        hold;
  logic [7:0]  wr_en;
  logic [15:0] wr_data;

  regfile_wb_arbiter #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ack   (a_ack),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .m_ack   (m_ack),
    .hold    (hold),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // model: 0 none, 1 ALU, 2 load
  bit          mdl_armed;
  int          mdl_prev;
  int          mdl_last;
  bit          sampled;
  logic [7:0]  exp_en;
  logic [15:0] exp_data;
  logic        exp_aa;
  logic        exp_ma;
  int          a_wait;
  int          m_wait;
  logic [15:0] rf [8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_armed = 1'b0;
    mdl_prev  = 0;
    mdl_last  = 1;
    sampled   = 1'b0;
    exp_en    = 8'h00;
    exp_data  = 16'h0000;
    exp_aa    = 1'b0;
    exp_ma    = 1'b0;
    a_wait    = 0;
    m_wait    = 0;
  endtask

  task automatic model_update();
    bit ea;
    bit em;
    int win;
    sampled = 1'b0;
    exp_aa  = 1'b0;
    exp_ma  = 1'b0;
    exp_en  = 8'h00;
    if (!rst_n) begin
      model_reset();
    end else if (!mdl_armed) begin
      mdl_armed = 1'b1;
      mdl_prev  = 0;
    end else begin
      sampled = 1'b1;
      ea = a_req && !hold && mdl_prev != 1;
      em = m_req && !hold && mdl_prev != 2;
      win = 0;
      if (ea && em)
        win = (a_addr == m_addr) ? 2 : (mdl_last == 1 ? 2 : 1);
      else if (ea)
        win = 1;
      else if (em)
        win = 2;
      mdl_prev = win;
      if (win == 1) begin
        mdl_last = 1;
        exp_en   = 8'h01 << a_addr;
        exp_data = a_data;
        exp_aa   = 1'b1;
      end else if (win == 2) begin
        mdl_last = 2;
        exp_en   = 8'h01 << m_addr;
        exp_data = m_data;
        exp_ma   = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    chk("wr_data", 32'(wr_data), 32'(exp_data));
    chk("a_ack", 32'(a_ack), 32'(exp_aa));
    chk("m_ack", 32'(m_ack), 32'(exp_ma));
    chk("onehot", 32'($countones(wr_en) <= 1), 32'd1);
    chk("ack_excl", 32'(a_ack && m_ack), 32'd0);
    for (int i = 0; i < 8; i++)
      if (wr_en[i]) rf[i] = wr_data;
    if (sampled && a_req && !a_ack && !hold) a_wait++;
    else a_wait = 0;
    if (sampled && m_req && !m_ack && !hold) m_wait++;
    else m_wait = 0;
    chk("a_starve", 32'(a_wait > 2), 32'd0);
    chk("m_starve", 32'(m_wait > 2), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  // called at a negedge; leaves reset released at the next negedge
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_acks", 32'({a_ack, m_ack}), 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_a(logic r, logic [2:0] ad, logic [15:0] d);
    a_req = r; a_addr = ad; a_data = d;
  endtask

  task automatic set_m(logic r, logic [2:0] ad, logic [15:0] d);
    m_req = r; m_addr = ad; m_data = d;
  endtask

  logic [7:0] pat [4];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rst_n = 1'b0;
    hold  = 1'b0;
    set_a(1'b0, 3'd0, 16'h0);
    set_m(1'b0, 3'd0, 16'h0);
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // single ALU write
    set_a(1'b1, 3'd3, 16'h1234);
    step();
    chk("first_edge_en", 32'(wr_en), 32'h0);
    chk("first_edge_ack", 32'(a_ack), 32'h0);
    step();
    chk("alu_en", 32'(wr_en), 32'h08);
    chk("alu_data", 32'(wr_data), 32'h1234);
    chk("alu_ack", 32'(a_ack), 32'h1);
    set_a(1'b0, 3'd3, 16'h1234);
    step();
    chk("alu_ack_drop", 32'(a_ack), 32'h0);
    chk("data_kept", 32'(wr_data), 32'h1234);

    // alternation after reset
    reset_pulse();
    set_a(1'b1, 3'd1, 16'h0A0A);
    set_m(1'b1, 3'd6, 16'h0B0B);
    step();
    chk("rr_first_edge", 32'(wr_en), 32'h0);
    pat[0] = 8'h40; pat[1] = 8'h02;
    pat[2] = 8'h40; pat[3] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_pattern", 32'(wr_en), 32'(pat[i]));
    end
    set_a(1'b0, 3'd1, 16'h0A0A);
    set_m(1'b0, 3'd6, 16'h0B0B);
    step();

    // same destination ordering
    set_a(1'b1, 3'd5, 16'h00AA);
    set_m(1'b1, 3'd5, 16'h00BB);
    step();
    chk("same_first", 32'(wr_data), 32'h00BB);
    chk("same_first_mack", 32'(m_ack), 32'h1);
    set_m(1'b0, 3'd5, 16'h00BB);
    step();
    chk("same_second", 32'(wr_data), 32'h00AA);
    set_a(1'b0, 3'd5, 16'h00AA);
    step();
    chk("reg5_final", 32'(rf[5]), 32'h00AA);

    // hold
    set_a(1'b1, 3'd2, 16'h1111);
    set_m(1'b1, 3'd4, 16'h2222);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_en", 32'(wr_en), 32'h0);
      chk("hold_acks", 32'({a_ack, m_ack}), 32'h0);
    end
    hold = 1'b0;
    step();
    chk("hold_release", 32'(wr_en), 32'h10);
    set_m(1'b0, 3'd4, 16'h2222);
    step();
    chk("hold_second", 32'(wr_en), 32'h04);
    set_a(1'b0, 3'd2, 16'h1111);
    step();

    // reset mid-stream
    set_a(1'b1, 3'd0, 16'h3333);
    set_m(1'b1, 3'd7, 16'h4444);
    step();
    reset_pulse();
    step();
    chk("post_rst_edge", 32'({a_ack, m_ack}), 32'h0);
    step();
    chk("post_rst_m", 32'(wr_en), 32'h80);
    step();
    chk("post_rst_a", 32'(wr_en), 32'h01);
    set_a(1'b0, 3'd0, 16'h0);
    set_m(1'b0, 3'd0, 16'h0);
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (a_req && a_ack)
        set_a(($urandom % 3) != 0, 3'($urandom), 16'($urandom));
      else if (a_req)
        a_req = ($urandom % 40) != 0;
      else if (($urandom % 2) == 0)
        set_a(1'b1, 3'($urandom), 16'($urandom));
      if (m_req && m_ack)
        set_m(($urandom % 3) != 0, 3'($urandom), 16'($urandom));
      else if (m_req)
        m_req = ($urandom % 40) != 0;
      else if (($urandom % 2) == 0)
        set_m(1'b1, 3'($urandom), 16'($urandom));
      if (($urandom % 8) == 0) hold = ~hold;
      if (($urandom % 500) == 0) reset_pulse();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
